// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_access_pkg
// Description : Size codes, FSM state encoding and lane-mask helpers shared by
//               the data-memory access unit and its load aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int IO_BIT_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Ones over the low (8 << size) bits of a dword.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Byte-offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts a byte/half/word/dword lane from a memory dword and
//               sign- or zero-extends it to 64 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_access_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [63:0] o_result
);

    logic [63:0] w_shifted;

    assign w_shifted = i_dword >> {i_off, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_size)
            SZ_B:    o_result = {{56{i_signed & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_result = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_result = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Pipeline-side load/store initiator for the dword data-memory /
//               IO port: lane extraction, extension and sub-dword RMW stores.
//               Optional macro MISALIGN_TRAP_EN turns misaligned accesses into
//               faults instead of silently aligning the offset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IO_BIT = IO_BIT_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [63:0]       mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_enable_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    state_t              r_state;
    logic                r_write;
    logic                r_signed;
    logic                r_io;
    logic [1:0]          r_size;
    logic [2:0]          r_off;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [63:0]         r_mem_address;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;

    logic                w_accept;
    logic                w_io_in;
    logic [2:0]          w_align_in;
    logic [2:0]          w_off_in;
    logic [5:0]          w_shift;
    logic [DATA_W-1:0]   w_lane_mask;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_load_data;

    assign w_accept   = req_valid & r_ready;
    assign w_io_in    = req_addr[IO_BIT+3];
    assign w_align_in = align_mask(req_size);
    // Aligned accesses are unaffected; misaligned ones fall back to the lane start.
    assign w_off_in   = req_addr[2:0] & ~w_align_in;

`ifdef MISALIGN_TRAP_EN
    logic w_misalign_in;
    logic r_fault;
    assign w_misalign_in = |(req_addr[2:0] & w_align_in);
    assign rsp_fault     = r_fault;
`else
    assign rsp_fault     = 1'b0;
`endif

    assign w_shift     = {r_off, 3'b000};
    assign w_lane_mask = size_mask(r_size) << w_shift;
    assign w_merged    = (mem_data_read & ~w_lane_mask)
                       | ((r_wdata & size_mask(r_size)) << w_shift);

    // The READ-cycle memory word feeds the response/merge registers directly,
    // so the captured dword lives in rsp_rdata or mem_data_write.
    load_align u_load_align (
        .i_dword  (mem_data_read),
        .i_off    (r_io ? 3'b000 : r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_result (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_write       <= 1'b0;
            r_signed      <= 1'b0;
            r_io          <= 1'b0;
            r_size        <= SZ_B;
            r_off         <= 3'd0;
            r_wdata       <= '0;
            r_ready       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_address <= 64'd0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_fault       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_write  <= req_write;
                        r_signed <= req_signed;
                        r_io     <= w_io_in;
                        r_size   <= req_size;
                        r_off    <= w_off_in;
                        r_wdata  <= req_wdata;
`ifdef MISALIGN_TRAP_EN
                        if (w_misalign_in) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_fault     <= 1'b1;
                        end else
`endif
                        if (!req_write || (!w_io_in && req_size != SZ_D)) begin
                            r_state       <= ST_READ;
                            r_mem_address <= {3'b000, req_addr[63:3]};
                        end else begin
                            // Full-dword RAM and all IO stores need no merge.
                            r_state       <= ST_WRITE;
                            r_mem_address <= {3'b000, req_addr[63:3]};
                            r_mem_we      <= 1'b1;
                            r_mem_wdata   <= req_wdata & size_mask(req_size);
                        end
                    end
                end
                ST_READ: begin
                    if (!r_write) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_data;
                    end else begin
                        r_state     <= ST_WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_RESP;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                end
                ST_RESP: begin
                    r_state       <= ST_IDLE;
                    r_rsp_valid   <= 1'b0;
                    r_rsp_rdata   <= '0;
                    r_mem_address <= 64'd0;
                    r_ready       <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                    r_fault       <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = r_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rsp_rdata;
    assign mem_address      = r_mem_address;
    assign mem_data_write   = r_mem_wdata;
    assign mem_enable_write = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a small
//               RAM/IO memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_data_write;
    logic        mem_enable_write;
    logic [63:0] mem_data_read;

    logic [63:0] ram [0:15];
    logic [63:0] io_sw = 64'h0;
    logic [63:0] io_last = 64'h0;
    int          strobes = 0;
    int          rsps = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_fault        (rsp_fault),
        .mem_address      (mem_address),
        .mem_data_write   (mem_data_write),
        .mem_enable_write (mem_enable_write),
        .mem_data_read    (mem_data_read)
    );

    assign mem_data_read = mem_address[12] ? io_sw : ram[mem_address[3:0]];

    always @(posedge clk) begin
        if (mem_enable_write) begin
            strobes <= strobes + 1;
            if (mem_address[12]) io_last <= mem_data_write;
            else                 ram[mem_address[3:0]] <= mem_data_write;
        end
        if (rsp_valid) rsps <= rsps + 1;
    end

    // Drives one request from a negedge; reports latency in cycles from the
    // accept cycle to the rsp_valid cycle (99 on timeout).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output int lat, output logic [63:0] rdata,
                          output logic fault, output logic [63:0] addr_seen,
                          output int nstb);
        int n;
        int s0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        s0 = strobes;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rdata = 64'hDEAD;
        fault = 1'b0;
        addr_seen = 64'hFFFF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) addr_seen = mem_address;
            if (rsp_valid) begin
                lat = c;
                rdata = rsp_rdata;
                fault = rsp_fault;
                break;
            end
        end
        @(negedge clk);
        nstb = strobes - s0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin
            bad++;
            $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h required 0/0/0", req_ready, rsp_valid, rsp_rdata);
        end
        total++;
        if (mem_address !== 64'd0 || mem_data_write !== 64'd0 || mem_enable_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem: addr=%h wd=%h we=%b required 0/0/0", mem_address, mem_data_write, mem_enable_write);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_loads;
        int lat; logic [63:0] rd; logic f; logic [63:0] a; int ns;
        ram[5] = 64'h8877_6655_4433_2211;
        do_req(1'b0, 2'd0, 1'b1, 64'h2D, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'h66 || lat != 2 || a !== 64'd5 || ns != 0) begin
            bad++;
            $display("FAIL load_b_signed: rdata=%h lat=%0d addr=%h stb=%0d required 66/2/5/0", rd, lat, a, ns);
        end
        do_req(1'b0, 2'd1, 1'b1, 64'h2E, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'hFFFF_FFFF_FFFF_8877 || lat != 2) begin
            bad++;
            $display("FAIL load_h_signed: rdata=%h lat=%0d required ffffffffffff8877/2", rd, lat);
        end
        do_req(1'b0, 2'd2, 1'b0, 64'h2C, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'h8877_6655) begin
            bad++;
            $display("FAIL load_w_unsigned: rdata=%h required 0000000088776655", rd);
        end
        do_req(1'b0, 2'd0, 1'b1, 64'h2F, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FF88) begin
            bad++;
            $display("FAIL load_b_neg: rdata=%h required ffffffffffffff88", rd);
        end
        do_req(1'b0, 2'd0, 1'b0, 64'h2F, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'h88) begin
            bad++;
            $display("FAIL load_b_zext: rdata=%h required 88", rd);
        end
        do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'h8877_6655_4433_2211 || f !== 1'b0) begin
            bad++;
            $display("FAIL load_d: rdata=%h fault=%b required 8877665544332211/0", rd, f);
        end
    endtask

    task automatic test_stores;
        int lat; logic [63:0] rd; logic f; logic [63:0] a; int ns;
        do_req(1'b1, 2'd0, 1'b0, 64'h29, 64'hAB, lat, rd, f, a, ns);
        total++;
        if (ram[5] !== 64'h8877_6655_4433_AB11 || lat != 3 || ns != 1 || rd !== 64'd0) begin
            bad++;
            $display("FAIL store_b: ram=%h lat=%0d stb=%0d rdata=%h required 887766554433ab11/3/1/0", ram[5], lat, ns, rd);
        end
        ram[6] = 64'd0;
        do_req(1'b1, 2'd1, 1'b0, 64'h34, 64'hFFFF_1234, lat, rd, f, a, ns);
        total++;
        if (ram[6] !== 64'h0000_1234_0000_0000 || lat != 3) begin
            bad++;
            $display("FAIL store_h: ram=%h lat=%0d required 0000123400000000/3", ram[6], lat);
        end
        do_req(1'b1, 2'd3, 1'b0, 64'h38, 64'h0123_4567_89AB_CDEF, lat, rd, f, a, ns);
        total++;
        if (ram[7] !== 64'h0123_4567_89AB_CDEF || lat != 2 || ns != 1) begin
            bad++;
            $display("FAIL store_d: ram=%h lat=%0d stb=%0d required 0123456789abcdef/2/1", ram[7], lat, ns);
        end
        do_req(1'b0, 2'd0, 1'b0, 64'h3A, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'hAB) begin
            bad++;
            $display("FAIL store_d_readback: rdata=%h required ab", rd);
        end
    endtask

    task automatic test_io;
        int lat; logic [63:0] rd; logic f; logic [63:0] a; int ns;
        do_req(1'b1, 2'd3, 1'b0, 64'h8000, 64'h5A, lat, rd, f, a, ns);
        total++;
        if (io_last !== 64'h5A || lat != 2 || ns != 1 || a !== 64'h1000) begin
            bad++;
            $display("FAIL io_store_d: io=%h lat=%0d stb=%0d addr=%h required 5a/2/1/1000", io_last, lat, ns, a);
        end
        do_req(1'b1, 2'd0, 1'b0, 64'h8003, 64'h77FF, lat, rd, f, a, ns);
        total++;
        if (io_last !== 64'hFF || lat != 2) begin
            bad++;
            $display("FAIL io_store_b: io=%h lat=%0d required ff/2", io_last, lat);
        end
        io_sw = 64'h0000_0000_0000_00C3;
        do_req(1'b0, 2'd0, 1'b0, 64'h8000, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'hC3 || lat != 2) begin
            bad++;
            $display("FAIL io_load_u: rdata=%h lat=%0d required c3/2", rd, lat);
        end
        do_req(1'b0, 2'd0, 1'b1, 64'h8005, 64'd0, lat, rd, f, a, ns);
        total++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFC3) begin
            bad++;
            $display("FAIL io_load_s_off: rdata=%h required ffffffffffffffc3", rd);
        end
    endtask

    task automatic test_misalign;
        int lat; logic [63:0] rd; logic f; logic [63:0] a; int ns;
        ram[5] = 64'h8877_6655_4433_2211;
        do_req(1'b0, 2'd2, 1'b0, 64'h2A, 64'd0, lat, rd, f, a, ns);
`ifdef MISALIGN_TRAP_EN
        total++;
        if (f !== 1'b1 || lat != 1 || rd !== 64'd0 || ns != 0) begin
            bad++;
            $display("FAIL misalign_load: fault=%b lat=%0d rdata=%h stb=%0d required 1/1/0/0", f, lat, rd, ns);
        end
        do_req(1'b1, 2'd1, 1'b0, 64'h2B, 64'hBEEF, lat, rd, f, a, ns);
        total++;
        if (ram[5] !== 64'h8877_6655_4433_2211 || f !== 1'b1 || ns != 0) begin
            bad++;
            $display("FAIL misalign_store: ram=%h fault=%b stb=%0d required 8877665544332211/1/0", ram[5], f, ns);
        end
`else
        total++;
        if (rd !== 64'h4433_2211 || f !== 1'b0 || lat != 2) begin
            bad++;
            $display("FAIL misalign_load: rdata=%h fault=%b lat=%0d required 44332211/0/2", rd, f, lat);
        end
        do_req(1'b1, 2'd1, 1'b0, 64'h2B, 64'hBEEF, lat, rd, f, a, ns);
        total++;
        if (ram[5] !== 64'h8877_6655_BEEF_2211 || f !== 1'b0) begin
            bad++;
            $display("FAIL misalign_store: ram=%h fault=%b required 88776655beef2211/0", ram[5], f);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int r0;
        int n;
        ram[5] = 64'h8877_6655_4433_2211;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 64'h29;
        req_wdata = 64'hAB;
        r0 = rsps;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_enable_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_we: got %b required 0", mem_enable_write);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready !== 1'b1 || ram[5] !== 64'h8877_6655_4433_2211 || rsps != r0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b ram=%h rsps=%0d required 1/8877665544332211/%0d", req_ready, ram[5], rsps, r0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 64'd0;
        test_reset();
        test_loads();
        test_stores();
        test_io();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
